// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared types for the dual-lane MEM stage: the FSM state encoding, the
//   per-lane bundle carried from the EX/MEM register, and helpers that
//   classify a lane's memory operation.
//   Lane widths are fixed here; a top-level DW/RW override must match them.
package mem_stage_pkg;

  localparam int LANE_DW = 32;
  localparam int LANE_RW = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [LANE_DW-1:0] res;
    logic [LANE_DW-1:0] wdata;
    logic [LANE_RW-1:0] rd;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               regwrite;
  } lane_t;

  function automatic logic is_mem_op(lane_t l);
    return l.memread | l.memwrite;
  endfunction

  // A lane with both memread and memwrite set behaves as a store.
  function automatic logic is_load(lane_t l);
    return l.memread & ~l.memwrite;
  endfunction

endpackage

// File: rtl/mem_wb_lane_reg.sv
// mem_wb_lane_reg
//   One lane of MEM/WB state: the load buffer that captures returned (or
//   forwarded) load data, the writeback select, and the registered wb_*
//   outputs. Instantiated once per lane by mem_wb_stage.
// Ports
//   clk, reset      clock, synchronous active-high reset
//   i_res           ALU result of the lane (non-load writeback value)
//   i_rd            destination register
//   i_memtoreg      writeback selects the load buffer
//   i_regwrite      lane writes the register file
//   i_ld_en         capture i_ld_data into the load buffer
//   i_ld_data       load data (memory return or forwarded store data)
//   i_commit        this edge commits the lane into the wb_* registers
//   o_wb_data       registered writeback value
//   o_wb_rd         registered writeback register
//   o_wb_regwrite   registered writeback enable (0 on every non-commit edge)
module mem_wb_lane_reg
  import mem_stage_pkg::*;
#(
  parameter int DW = LANE_DW,
  parameter int RW = LANE_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_res,
  input  logic [RW-1:0] i_rd,
  input  logic          i_memtoreg,
  input  logic          i_regwrite,
  input  logic          i_ld_en,
  input  logic [DW-1:0] i_ld_data,
  input  logic          i_commit,
  output logic [DW-1:0] o_wb_data,
  output logic [RW-1:0] o_wb_rd,
  output logic          o_wb_regwrite
);

  logic [DW-1:0] r_ldbuf;
  logic [DW-1:0] r_wb_data;
  logic [RW-1:0] r_wb_rd;
  logic          r_wb_regwrite;

  // Capture and commit never fall on the same edge: capture happens in the
  // REQ/WAIT states, commit only in IDLE (no mem op) or DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ldbuf       <= '0;
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
    end else begin
      if (i_ld_en) begin
        r_ldbuf <= i_ld_data;
      end
      if (i_commit) begin
        r_wb_data     <= i_memtoreg ? r_ldbuf : i_res;
        r_wb_rd       <= i_rd;
        r_wb_regwrite <= i_regwrite;
      end else begin
        // Bubble: data and rd hold, only the enable drops.
        r_wb_regwrite <= 1'b0;
      end
    end
  end

  assign o_wb_data     = r_wb_data;
  assign o_wb_rd       = r_wb_rd;
  assign o_wb_regwrite = r_wb_regwrite;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Dual-lane MEM stage between the EX/MEM register and writeback. Both
//   lanes' loads/stores are serialised onto a single-ported data-memory
//   request/grant/rvalid handshake, lane 1 first. Upstream is stalled while
//   memory work is pending; both lanes then commit together into MEM/WB.
// Optional feature (macro MEM_ST_LD_FWD_EN)
//   When defined, a lane 2 load from the exact address stored by lane 1 is
//   satisfied from lane 1's store data and issues no memory request.
//   When undefined, lane 2 reads memory after the lane 1 store completes.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_alu_res_1/_2             lane ALU result, also the byte address
//   i_wdata_1/_2               lane store data
//   i_rd_1/_2                  lane destination register
//   i_memread_1/_2             lane load
//   i_memwrite_1/_2            lane store (wins over memread)
//   i_memtoreg_1/_2            writeback selects load data
//   i_regwrite_1/_2            lane writes the register file
//   o_mem_stall                holds EX/MEM and earlier stages
//   o_dmem_req/we/addr/wdata   memory request, held until i_dmem_gnt
//   i_dmem_gnt                 request accepted this cycle
//   i_dmem_rvalid/rdata        load return
//   o_wb_data/rd/regwrite_1/_2 registered writeback outputs
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = LANE_DW,
  parameter int RW = LANE_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_alu_res_1,
  input  logic [DW-1:0] i_alu_res_2,
  input  logic [DW-1:0] i_wdata_1,
  input  logic [DW-1:0] i_wdata_2,
  input  logic [RW-1:0] i_rd_1,
  input  logic [RW-1:0] i_rd_2,
  input  logic          i_memread_1,
  input  logic          i_memread_2,
  input  logic          i_memwrite_1,
  input  logic          i_memwrite_2,
  input  logic          i_memtoreg_1,
  input  logic          i_memtoreg_2,
  input  logic          i_regwrite_1,
  input  logic          i_regwrite_2,
  output logic          o_mem_stall,
  output logic          o_dmem_req,
  output logic          o_dmem_we,
  output logic [DW-1:0] o_dmem_addr,
  output logic [DW-1:0] o_dmem_wdata,
  input  logic          i_dmem_gnt,
  input  logic          i_dmem_rvalid,
  input  logic [DW-1:0] i_dmem_rdata,
  output logic [DW-1:0] o_wb_data_1,
  output logic [DW-1:0] o_wb_data_2,
  output logic [RW-1:0] o_wb_rd_1,
  output logic [RW-1:0] o_wb_rd_2,
  output logic          o_wb_regwrite_1,
  output logic          o_wb_regwrite_2
);

  lane_t  w_lane1;
  lane_t  w_lane2;
  state_t r_state;
  state_t w_next;

  logic   w_op1;
  logic   w_op2;
  logic   w_fwd;
  logic   w_pend2;
  logic   w_commit;
  logic   w_ld1;
  logic   w_ld2;
  logic   w_fwd_ld;

  assign w_lane1 = '{res: i_alu_res_1, wdata: i_wdata_1, rd: i_rd_1,
                     memread: i_memread_1, memwrite: i_memwrite_1,
                     memtoreg: i_memtoreg_1, regwrite: i_regwrite_1};
  assign w_lane2 = '{res: i_alu_res_2, wdata: i_wdata_2, rd: i_rd_2,
                     memread: i_memread_2, memwrite: i_memwrite_2,
                     memtoreg: i_memtoreg_2, regwrite: i_regwrite_2};

  assign w_op1 = is_mem_op(w_lane1);
  assign w_op2 = is_mem_op(w_lane2);

`ifdef MEM_ST_LD_FWD_EN
  // Only an effective load on lane 2 can be forwarded; a lane 2 store
  // (even with memread set) must still reach memory.
  assign w_fwd = w_lane1.memwrite & is_load(w_lane2) &
                 (w_lane1.res == w_lane2.res);
`else
  assign w_fwd = 1'b0;
`endif

  // Lane 2 still needs the memory port after lane 1 finishes.
  assign w_pend2 = w_op2 & ~w_fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_commit     = 1'b0;
    w_ld1        = 1'b0;
    w_ld2        = 1'b0;
    w_fwd_ld     = 1'b0;
    o_mem_stall  = 1'b0;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_op1 | w_op2) begin
          o_mem_stall = 1'b1;
          w_next      = w_op1 ? REQ1 : REQ2;
        end else begin
          w_commit = 1'b1;
        end
      end
      REQ1: begin
        o_mem_stall  = 1'b1;
        o_dmem_req   = 1'b1;
        o_dmem_we    = w_lane1.memwrite;
        o_dmem_addr  = w_lane1.res;
        o_dmem_wdata = w_lane1.wdata;
        if (i_dmem_gnt) begin
          if (w_lane1.memwrite) begin
            w_fwd_ld = w_fwd;
            w_next   = w_pend2 ? REQ2 : DONE;
          end else begin
            w_next = WAIT1;
          end
        end
      end
      WAIT1: begin
        o_mem_stall = 1'b1;
        if (i_dmem_rvalid) begin
          w_ld1  = 1'b1;
          w_next = w_pend2 ? REQ2 : DONE;
        end
      end
      REQ2: begin
        o_mem_stall  = 1'b1;
        o_dmem_req   = 1'b1;
        o_dmem_we    = w_lane2.memwrite;
        o_dmem_addr  = w_lane2.res;
        o_dmem_wdata = w_lane2.wdata;
        if (i_dmem_gnt) begin
          w_next = w_lane2.memwrite ? DONE : WAIT2;
        end
      end
      WAIT2: begin
        o_mem_stall = 1'b1;
        if (i_dmem_rvalid) begin
          w_ld2  = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        w_commit = 1'b1;
        w_next   = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  mem_wb_lane_reg #(.DW(DW), .RW(RW)) u_lane1 (
    .clk           (clk),
    .reset         (reset),
    .i_res         (w_lane1.res),
    .i_rd          (w_lane1.rd),
    .i_memtoreg    (w_lane1.memtoreg),
    .i_regwrite    (w_lane1.regwrite),
    .i_ld_en       (w_ld1),
    .i_ld_data     (i_dmem_rdata),
    .i_commit      (w_commit),
    .o_wb_data     (o_wb_data_1),
    .o_wb_rd       (o_wb_rd_1),
    .o_wb_regwrite (o_wb_regwrite_1)
  );

  // Lane 2's buffer is also the landing point for forwarded store data.
  mem_wb_lane_reg #(.DW(DW), .RW(RW)) u_lane2 (
    .clk           (clk),
    .reset         (reset),
    .i_res         (w_lane2.res),
    .i_rd          (w_lane2.rd),
    .i_memtoreg    (w_lane2.memtoreg),
    .i_regwrite    (w_lane2.regwrite),
    .i_ld_en       (w_ld2 | w_fwd_ld),
    .i_ld_data     (w_fwd_ld ? w_lane1.wdata : i_dmem_rdata),
    .i_commit      (w_commit),
    .o_wb_data     (o_wb_data_2),
    .o_wb_rd       (o_wb_rd_2),
    .o_wb_regwrite (o_wb_regwrite_2)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam logic [3:0] C_RD  = 4'b1000;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_M2R = 4'b0010;
  localparam logic [3:0] C_RW  = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_alu_res_1, i_alu_res_2, i_wdata_1, i_wdata_2;
  logic [4:0]  i_rd_1, i_rd_2;
  logic        i_memread_1, i_memread_2, i_memwrite_1, i_memwrite_2;
  logic        i_memtoreg_1, i_memtoreg_2, i_regwrite_1, i_regwrite_2;
  logic        o_mem_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_wb_data_1, o_wb_data_2;
  logic [4:0]  o_wb_rd_1, o_wb_rd_2;
  logic        o_wb_regwrite_1, o_wb_regwrite_2;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .i_alu_res_1(i_alu_res_1), .i_alu_res_2(i_alu_res_2),
    .i_wdata_1(i_wdata_1), .i_wdata_2(i_wdata_2),
    .i_rd_1(i_rd_1), .i_rd_2(i_rd_2),
    .i_memread_1(i_memread_1), .i_memread_2(i_memread_2),
    .i_memwrite_1(i_memwrite_1), .i_memwrite_2(i_memwrite_2),
    .i_memtoreg_1(i_memtoreg_1), .i_memtoreg_2(i_memtoreg_2),
    .i_regwrite_1(i_regwrite_1), .i_regwrite_2(i_regwrite_2),
    .o_mem_stall(o_mem_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_data_1(o_wb_data_1), .o_wb_data_2(o_wb_data_2),
    .o_wb_rd_1(o_wb_rd_1), .o_wb_rd_2(o_wb_rd_2),
    .o_wb_regwrite_1(o_wb_regwrite_1), .o_wb_regwrite_2(o_wb_regwrite_2)
  );

  typedef struct {
    logic [31:0] a1, w1, a2, w2;
    logic [4:0]  r1, r2;
    logic [3:0]  c1, c2;   // {memread, memwrite, memtoreg, regwrite}
    int          g, d;     // grant delay, rvalid delay after grant
  } pair_t;

  typedef struct {
    string       name;
    pair_t       p;
    logic [31:0] e_d1, e_d2;
    logic        e_rw1, e_rw2;
    int          e_lat, e_nacc;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  int n_checks = 0;
  int n_pass   = 0;
  int unstable = 0;
  int cur_g = 0;
  int cur_d = 1;

  acc_t log_q[$];
  acc_t exp_q[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] m_ld1 = '0, m_ld2 = '0;
  logic [31:0] prev_d1 = '0, prev_d2 = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory responder: grants after cur_g waiting cycles, returns load data
  // cur_d cycles after the grant cycle, and logs every accepted request.
  initial begin
    logic        act;
    int          cnt, rv_cnt;
    logic [31:0] rv_data, f_addr, f_wd;
    logic        f_we;
    i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = '0;
    act = 0; cnt = 0; rv_cnt = 0; rv_data = '0;
    f_addr = '0; f_wd = '0; f_we = 0;
    forever begin
      @(negedge clk);
      i_dmem_gnt = 0;
      i_dmem_rvalid = 0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          i_dmem_rvalid = 1;
          i_dmem_rdata  = rv_data;
        end
      end
      if (o_dmem_req === 1'b1) begin
        if (!act) begin
          act = 1; cnt = 0;
          f_addr = o_dmem_addr; f_wd = o_dmem_wdata; f_we = o_dmem_we;
        end else if (f_addr !== o_dmem_addr || f_wd !== o_dmem_wdata || f_we !== o_dmem_we) begin
          unstable++;
        end
        if (cnt >= cur_g) begin
          i_dmem_gnt = 1;
          act = 0;
          log_q.push_back('{we: o_dmem_we, addr: o_dmem_addr,
                            wdata: o_dmem_we ? o_dmem_wdata : 32'h0});
          if (o_dmem_we) mem[o_dmem_addr] = o_dmem_wdata;
          else begin
            rv_data = mem_rd(o_dmem_addr);
            rv_cnt  = cur_d;
          end
        end else begin
          cnt++;
        end
      end else begin
        act = 0;
      end
    end
  end

  function automatic pair_t mkp(logic [31:0] a1, logic [31:0] w1, logic [4:0] r1, logic [3:0] c1,
                                logic [31:0] a2, logic [31:0] w2, logic [4:0] r2, logic [3:0] c2,
                                int g, int d);
    pair_t p;
    p.a1 = a1; p.w1 = w1; p.r1 = r1; p.c1 = c1;
    p.a2 = a2; p.w2 = w2; p.r2 = r2; p.c2 = c2;
    p.g = g; p.d = d;
    return p;
  endfunction

  function automatic vec_t mkv(string n, pair_t p, logic [31:0] d1, logic [31:0] d2,
                               logic rw1, logic rw2, int lat, int nacc);
    vec_t v;
    v.name = n; v.p = p; v.e_d1 = d1; v.e_d2 = d2;
    v.e_rw1 = rw1; v.e_rw2 = rw2; v.e_lat = lat; v.e_nacc = nacc;
    return v;
  endfunction

  task automatic apply(pair_t p);
    i_alu_res_1 = p.a1; i_wdata_1 = p.w1; i_rd_1 = p.r1;
    {i_memread_1, i_memwrite_1, i_memtoreg_1, i_regwrite_1} = p.c1;
    i_alu_res_2 = p.a2; i_wdata_2 = p.w2; i_rd_2 = p.r2;
    {i_memread_2, i_memwrite_2, i_memtoreg_2, i_regwrite_2} = p.c2;
    cur_g = p.g; cur_d = p.d;
  endtask

  // Program-order reference: lane 1 then lane 2 against a flat memory.
  // Latency = IDLE + per access (grant wait + 1, plus rvalid delay for
  // loads) + DONE; a pair without memory ops commits on the first edge.
  task automatic model_pair(pair_t p, output logic [31:0] ed1, output logic [31:0] ed2,
                            output int elat);
    logic any;
    logic fwd;
    any = 0; elat = 1;
    if (p.c1[2]) begin
      ref_mem[p.a1] = p.w1;
      exp_q.push_back('{we: 1'b1, addr: p.a1, wdata: p.w1});
      elat += p.g + 1; any = 1;
    end else if (p.c1[3]) begin
      m_ld1 = ref_rd(p.a1);
      exp_q.push_back('{we: 1'b0, addr: p.a1, wdata: 32'h0});
      elat += p.g + 1 + p.d; any = 1;
    end
    fwd = 0;
`ifdef MEM_ST_LD_FWD_EN
    fwd = p.c1[2] && p.c2[3] && !p.c2[2] && (p.a1 == p.a2);
`endif
    if (p.c2[2]) begin
      ref_mem[p.a2] = p.w2;
      exp_q.push_back('{we: 1'b1, addr: p.a2, wdata: p.w2});
      elat += p.g + 1; any = 1;
    end else if (p.c2[3]) begin
      m_ld2 = ref_rd(p.a2);
      any = 1;
      if (!fwd) begin
        exp_q.push_back('{we: 1'b0, addr: p.a2, wdata: 32'h0});
        elat += p.g + 1 + p.d;
      end
    end
    if (any) elat += 1;
    ed1 = p.c1[1] ? m_ld1 : p.a1;
    ed2 = p.c2[1] ? m_ld2 : p.a2;
  endtask

  // Applies a pair (called #1 after a negedge) and returns the number of
  // edges up to and including the commit edge.
  task automatic run_pair(string tag, pair_t p, output int lat);
    logic s, first;
    apply(p);
    #1;
    lat = 0; first = 1;
    do begin
      s = o_mem_stall;
      @(negedge clk); #1;
      lat++;
      if (first && s) begin
        check({tag, " bubble_rw"}, {o_wb_regwrite_1, o_wb_regwrite_2}, 2'b00);
        check({tag, " bubble_hold"}, {o_wb_data_1, o_wb_data_2}, {prev_d1, prev_d2});
      end
      first = 0;
    end while (s && lat < 200);
    if (lat >= 200) begin
      n_checks++;
      $display("FAIL %s timeout: stall still %0b after %0d cycles, required commit", tag, s, lat);
    end
  endtask

  task automatic check_log(string tag, int e_n);
    check({tag, " nacc"}, log_q.size(), e_n);
    check({tag, " nacc_model"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check({tag, " acc"}, {log_q[i].we, log_q[i].addr, log_q[i].wdata},
            {exp_q[i].we, exp_q[i].addr, exp_q[i].wdata});
    check({tag, " req_stable"}, unstable, 0);
    log_q.delete(); exp_q.delete(); unstable = 0;
  endtask

  initial begin
    vec_t        tbl[$];
    pair_t       p, nop;
    logic [31:0] ed1, ed2;
    int          elat, lat, t4_lat, t4_nacc;
    logic [31:0] addrs[4];

    addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h80; addrs[3] = 32'hC0;
    nop = mkp(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 1);
    reset = 1;
    apply(nop);
    repeat (3) @(negedge clk);
    #1;
    check("reset wb_data", {o_wb_data_1, o_wb_data_2}, 64'h0);
    check("reset wb_rd", {o_wb_rd_1, o_wb_rd_2}, 10'h0);
    check("reset wb_rw", {o_wb_regwrite_1, o_wb_regwrite_2}, 2'b00);
    check("reset req", o_dmem_req, 1'b0);
    check("reset stall", o_mem_stall, 1'b0);
    reset = 0;

    mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;

`ifdef MEM_ST_LD_FWD_EN
    t4_lat = 3; t4_nacc = 1;
`else
    t4_lat = 5; t4_nacc = 2;
`endif
    tbl.push_back(mkv("no_memop", mkp(32'h10, 0, 1, C_RW, 32'h20, 0, 2, C_RW, 0, 1),
                      32'h10, 32'h20, 1, 1, 1, 0));
    tbl.push_back(mkv("load_l1", mkp(32'h100, 0, 3, C_RD|C_M2R|C_RW, 32'h55, 0, 4, C_RW, 0, 2),
                      32'hDEADBEEF, 32'h55, 1, 1, 5, 1));
    tbl.push_back(mkv("two_stores", mkp(32'h40, 32'hA, 0, C_WR, 32'h44, 32'hB, 0, C_WR, 3, 1),
                      32'h40, 32'h44, 0, 0, 10, 2));
    tbl.push_back(mkv("st_ld_same", mkp(32'h80, 32'h1234, 5, C_WR, 32'h80, 0, 6, C_RD|C_M2R|C_RW, 0, 1),
                      32'h80, 32'h1234, 0, 1, t4_lat, t4_nacc));
    tbl.push_back(mkv("rd_wr_both", mkp(32'h200, 32'h77, 7, C_RD|C_WR|C_RW, 32'h300, 0, 8, 4'b0000, 0, 1),
                      32'h200, 32'h300, 1, 0, 3, 1));
    tbl.push_back(mkv("load_l2", mkp(32'h9, 0, 9, C_RW, 32'h44, 0, 10, C_RD|C_M2R|C_RW, 1, 1),
                      32'h9, 32'hB, 1, 1, 5, 1));

    foreach (tbl[i]) begin
      model_pair(tbl[i].p, ed1, ed2, elat);
      run_pair(tbl[i].name, tbl[i].p, lat);
      check({tbl[i].name, " lat"}, lat, tbl[i].e_lat);
      check({tbl[i].name, " wb_data_1"}, o_wb_data_1, tbl[i].e_d1);
      check({tbl[i].name, " wb_data_2"}, o_wb_data_2, tbl[i].e_d2);
      check({tbl[i].name, " wb_rw"}, {o_wb_regwrite_1, o_wb_regwrite_2}, {tbl[i].e_rw1, tbl[i].e_rw2});
      check({tbl[i].name, " wb_rd"}, {o_wb_rd_1, o_wb_rd_2}, {tbl[i].p.r1, tbl[i].p.r2});
      check_log(tbl[i].name, tbl[i].e_nacc);
      prev_d1 = tbl[i].e_d1; prev_d2 = tbl[i].e_d2;
    end

    // Reset while waiting for load data; the late rvalid must be dropped.
    p = mkp(32'h300, 0, 9, C_RD|C_M2R|C_RW, 0, 0, 0, 4'b0000, 0, 3);
    apply(p);
    @(negedge clk); #1;
    check("rst_wait req", o_dmem_req, 1'b1);
    @(negedge clk); #1;
    check("rst_wait in_wait", {o_mem_stall, o_dmem_req}, 2'b10);
    reset = 1;
    apply(nop);
    @(negedge clk); #1;
    check("rst_wait req_off", o_dmem_req, 1'b0);
    check("rst_wait wb_data", {o_wb_data_1, o_wb_data_2}, 64'h0);
    check("rst_wait wb_rd_rw", {o_wb_rd_1, o_wb_rd_2, o_wb_regwrite_1, o_wb_regwrite_2}, 12'h0);
    check("rst_wait stall", o_mem_stall, 1'b0);
    reset = 0;
    m_ld1 = '0; m_ld2 = '0; prev_d1 = '0; prev_d2 = '0;
    repeat (2) @(negedge clk);
    #1;
    log_q.delete(); exp_q.delete(); unstable = 0;
    p = mkp(32'h11, 0, 12, C_M2R|C_RW, 32'h22, 0, 13, C_M2R|C_RW, 0, 1);
    model_pair(p, ed1, ed2, elat);
    run_pair("rst_late_rvalid", p, lat);
    check("rst_late_rvalid ldbuf", {o_wb_data_1, o_wb_data_2}, {ed1, ed2});
    check("rst_late_rvalid lat", lat, elat);
    check_log("rst_late_rvalid", 0);
    prev_d1 = ed1; prev_d2 = ed2;

    // Randomised pairs against the reference model.
    for (int n = 0; n < 60; n++) begin
      int op1, op2;
      op1 = $urandom_range(0, 3);
      op2 = $urandom_range(0, 3);
      p.a1 = addrs[$urandom_range(0, 3)];
      p.a2 = addrs[$urandom_range(0, 3)];
      p.w1 = $urandom; p.w2 = $urandom;
      p.r1 = 5'($urandom); p.r2 = 5'($urandom);
      p.c1 = {op1 == 1 || op1 == 3, op1 >= 2, 1'($urandom), 1'($urandom)};
      p.c2 = {op2 == 1 || op2 == 3, op2 >= 2, 1'($urandom), 1'($urandom)};
      p.g = $urandom_range(0, 3);
      p.d = $urandom_range(1, 3);
      model_pair(p, ed1, ed2, elat);
      run_pair("rand", p, lat);
      check("rand lat", lat, elat);
      check("rand wb_data", {o_wb_data_1, o_wb_data_2}, {ed1, ed2});
      check("rand wb_rd", {o_wb_rd_1, o_wb_rd_2}, {p.r1, p.r2});
      check("rand wb_rw", {o_wb_regwrite_1, o_wb_regwrite_2}, {p.c1[0], p.c2[0]});
      check_log("rand", exp_q.size());
      prev_d1 = ed1; prev_d2 = ed2;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
